// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read handshake plus the IF/ID boundary
// (output register, stall and redirect inputs).
interface fetch_unit_if;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_valid;

  modport master (
    input  i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
    input  i_imem_ready, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_pc, o_instr, o_valid
  );

  modport slave (
    output i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
    output i_imem_ready, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_pc, o_instr, o_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ready read, next-PC select
// (+4 / branch / jump) and the IF/ID output register with stall and flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic        redirect;
  logic [31:0] target;
  logic        req;
  logic        fire;

  // Branch comes from EX and is older than a jump decoded in ID, so it wins.
  always_comb begin
    redirect = bus.i_branch_taken | bus.i_jump;
    target   = bus.i_branch_taken ? bus.i_branch_target : bus.i_jump_target;
    target   = target & 32'hFFFF_FFFC;
    accept   = ~valid_q | ~bus.i_stall;
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_BOOT;
    else          state_q <= state_d;
  end

  // FSM: next state -- one boot cycle, then RUN until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM: outputs. Request is purely combinational so an async reset drops it at once.
  always_comb begin
    req  = 1'b0;
    if (state_q == S_RUN) req = accept & ~redirect;
    fire = req & bus.i_imem_ready;
  end

  // Datapath next-state. Redirect overrides stall and discards any returning word.
  always_comb begin
    pc_d    = pc_q;
    opc_d   = opc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
    end else if (fire) begin
      pc_d    = pc_q + 32'd4;
      opc_d   = pc_q;
      instr_d = bus.i_imem_rdata;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      opc_q   <= 32'h0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = pc_q;
  assign bus.o_pc        = opc_q;
  assign bus.o_instr     = instr_q;
  assign bus.o_valid     = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// behavioural model of the fetch stage.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic clk    = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus0();
  fetch_unit_if bus1();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.i_clk(clk), .i_rst_n(rst0_n), .bus(bus0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.i_clk(clk), .i_rst_n(rst1_n), .bus(bus1));

  // Memory model: the word at address A is A ^ K
  assign bus0.i_imem_rdata = bus0.o_imem_addr ^ K;
  assign bus1.i_imem_rdata = bus1.o_imem_addr ^ K;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic r);
    bus0.i_stall         = s;
    bus0.i_branch_taken  = b;
    bus0.i_branch_target = bt;
    bus0.i_jump          = j;
    bus0.i_jump_target   = jt;
    bus0.i_imem_ready    = r;
  endtask

  // Leaves dut0 out of reset, mid-cycle, in its boot cycle
  task automatic reset0;
    rst0_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    rst0_n = 1'b1;
  endtask

  task automatic test_reset;
    rst0_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1);
    #3;
    total++; if (bus0.o_imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus0.o_imem_req); end
    total++; if (bus0.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus0.o_valid); end
    total++; if (bus0.o_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus0.o_pc); end
    total++; if (bus0.o_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", bus0.o_instr); end
    tick();
    total++; if (bus0.o_imem_req !== 1'b0) begin bad++; $display("FAIL rst_hold_req got=%b exp=0", bus0.o_imem_req); end
    rst0_n = 1'b1;
    #1;
    total++; if (bus0.o_imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", bus0.o_imem_req); end
    tick();
    total++; if (bus0.o_imem_req !== 1'b1 || bus0.o_imem_addr !== 32'h0) begin
      bad++; $display("FAIL run_req got=%b/%h exp=1/0", bus0.o_imem_req, bus0.o_imem_addr); end
  endtask

  task automatic test_sequential;
    reset0();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 32'(4*k) || bus0.o_instr !== (32'(4*k) ^ K)) begin
        bad++; $display("FAIL seq k=%0d got=%b/%h/%h exp=1/%h/%h", k, bus0.o_valid, bus0.o_pc,
                        bus0.o_instr, 32'(4*k), 32'(4*k) ^ K); end
    end
  endtask

  task automatic test_wait;
    reset0();
    tick();
    tick();
    tick();
    bus0.i_imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus0.o_imem_req !== 1'b1 || bus0.o_imem_addr !== 32'h8) begin
        bad++; $display("FAIL wait_req k=%0d got=%b/%h exp=1/8", k, bus0.o_imem_req, bus0.o_imem_addr); end
      tick();
      total++; if (bus0.o_valid !== 1'b0) begin bad++; $display("FAIL wait_valid k=%0d got=%b exp=0", k, bus0.o_valid); end
    end
    bus0.i_imem_ready = 1'b1;
    tick();
    total++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 32'h8 || bus0.o_instr !== (32'h8 ^ K)) begin
      bad++; $display("FAIL wait_done got=%b/%h/%h exp=1/8/%h", bus0.o_valid, bus0.o_pc, bus0.o_instr, 32'h8 ^ K); end
  endtask

  task automatic test_stall;
    reset0();
    tick();
    tick();
    tick();
    bus0.i_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus0.o_imem_req !== 1'b0 || bus0.o_imem_addr !== 32'h8) begin
        bad++; $display("FAIL stall_req k=%0d got=%b/%h exp=0/8", k, bus0.o_imem_req, bus0.o_imem_addr); end
      tick();
      total++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 32'h4 || bus0.o_instr !== (32'h4 ^ K)) begin
        bad++; $display("FAIL stall_hold k=%0d got=%b/%h/%h exp=1/4/%h", k, bus0.o_valid, bus0.o_pc,
                        bus0.o_instr, 32'h4 ^ K); end
    end
    bus0.i_stall = 1'b0;
    tick();
    total++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 32'h8) begin
      bad++; $display("FAIL stall_release got=%b/%h exp=1/8", bus0.o_valid, bus0.o_pc); end
  endtask

  task automatic test_redirect;
    reset0();
    tick();
    tick();
    set_in(1, 1, 32'h40, 1, 32'h80, 1);
    #1;
    total++; if (bus0.o_imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", bus0.o_imem_req); end
    tick();
    total++; if (bus0.o_valid !== 1'b0 || bus0.o_imem_addr !== 32'h40) begin
      bad++; $display("FAIL redir_flush got=%b/%h exp=0/40", bus0.o_valid, bus0.o_imem_addr); end
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    total++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 32'h40 || bus0.o_instr !== (32'h40 ^ K)) begin
      bad++; $display("FAIL redir_fetch got=%b/%h/%h exp=1/40/%h", bus0.o_valid, bus0.o_pc, bus0.o_instr, 32'h40 ^ K); end
  endtask

  task automatic test_jump_align;
    reset0();
    tick();
    set_in(0, 0, 0, 1, 32'h0000_0102, 1);
    tick();
    total++; if (bus0.o_imem_addr !== 32'h100) begin
      bad++; $display("FAIL jump_addr got=%h exp=100", bus0.o_imem_addr); end
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    total++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 32'h100) begin
      bad++; $display("FAIL jump_fetch got=%b/%h exp=1/100", bus0.o_valid, bus0.o_pc); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc;
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    tick();
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus1.o_valid !== 1'b1 || bus1.o_pc !== exp_pc || bus1.o_instr !== (exp_pc ^ K)) begin
        bad++; $display("FAIL wrap k=%0d got=%b/%h exp=1/%h", k, bus1.o_valid, bus1.o_pc, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
    #2;
    rst1_n = 1'b0;
    #1;
    total++; if (bus1.o_valid !== 1'b0 || bus1.o_imem_req !== 1'b0) begin
      bad++; $display("FAIL async_rst got=%b/%b exp=0/0", bus1.o_valid, bus1.o_imem_req); end
  endtask

  // Model: an instruction occupies the IF/ID slot until ID takes it (no stall)
  // or a redirect flushes it; a new one enters whenever memory answers an
  // allowed request.
  task automatic test_random;
    logic [31:0] m_pc, m_opc, m_instr, bt, jt;
    logic        m_valid, m_run, s, b, j, r, exp_req;
    reset0();
    m_pc = 32'h0; m_opc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_run = 1'b0;
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 11) == 0);
      j  = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 9) < 6);
      bt = $urandom;
      jt = $urandom;
      set_in(s, b, bt, j, jt, r);
      exp_req = m_run && (!m_valid || !s) && !(b || j);
      #1;
      total++; if (bus0.o_imem_req !== exp_req || bus0.o_imem_addr !== m_pc) begin
        bad++; $display("FAIL rnd_req n=%0d got=%b/%h exp=%b/%h", n, bus0.o_imem_req, bus0.o_imem_addr, exp_req, m_pc); end
      tick();
      if (b || j) begin
        m_pc    = (b ? bt : jt) & 32'hFFFF_FFFC;
        m_valid = 1'b0;
      end else if (exp_req && r) begin
        m_opc   = m_pc;
        m_instr = m_pc ^ K;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end else if (!m_valid || !s) begin
        m_valid = 1'b0;
      end
      m_run = 1'b1;
      total++; if (bus0.o_valid !== m_valid || bus0.o_pc !== m_opc || bus0.o_instr !== m_instr) begin
        bad++; $display("FAIL rnd_out n=%0d got=%b/%h/%h exp=%b/%h/%h", n, bus0.o_valid, bus0.o_pc,
                        bus0.o_instr, m_valid, m_opc, m_instr); end
    end
  endtask

  initial begin
    bus1.i_stall         = 1'b0;
    bus1.i_branch_taken  = 1'b0;
    bus1.i_branch_target = 32'h0;
    bus1.i_jump          = 1'b0;
    bus1.i_jump_target   = 32'h0;
    bus1.i_imem_ready    = 1'b1;
    set_in(0, 0, 0, 0, 0, 1);
    #2;
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_redirect();
    test_jump_align();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
